// File: rtl/output_drain_control.sv
// output_drain_control: captures a systolic-array result vector into a shadow register and
// writes it filter-major, one element per cycle, into the output RAM.
// Optional build macro OUTPUT_DRAIN_RELU_EN writes negative elements as zero.
module output_drain_control #(
    parameter int data_size     = 16,
    parameter int array_size    = 9,
    parameter int dim_data_size = 16,
    parameter int addr_width    = 14
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       enable,
    input  logic                                       start,
    input  logic [addr_width-1:0]                      initial_address,
    input  logic [dim_data_size-1:0]                   out_rows,
    input  logic [dim_data_size-1:0]                   number_filters,
    input  logic [data_size*array_size*array_size-1:0] result_in,
    output logic                                       ram_we,
    output logic [addr_width-1:0]                      ram_addr,
    output logic [data_size-1:0]                       ram_din,
    output logic                                       busy,
    output logic                                       done,
    output logic [1:0]                                 state_dbg
);
    localparam int n_elems = array_size * array_size;
    localparam int idx_w   = (n_elems > 1) ? $clog2(n_elems) : 1;
    localparam int wide_w  = addr_width + dim_data_size;
    localparam logic [dim_data_size-1:0] array_dim = dim_data_size'(array_size);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state, state_next;

    logic [data_size-1:0]     shadow [n_elems];
    logic [addr_width-1:0]    base;
    logic [dim_data_size-1:0] rows_eff, cols_eff, r_cnt, c_cnt;
    logic [dim_data_size-1:0] rows_clamp, cols_clamp;
    logic [idx_w-1:0]         elem_idx;
    logic [data_size-1:0]     elem, elem_out;
    logic [wide_w-1:0]        addr_wide;
    logic                     row_wrap, last_elem;

    assign rows_clamp = (out_rows > array_dim) ? array_dim : out_rows;
    assign cols_clamp = (number_filters > array_dim) ? array_dim : number_filters;
    assign row_wrap   = (r_cnt == rows_eff - 1'b1);
    assign last_elem  = row_wrap && (c_cnt == cols_eff - 1'b1);
    assign elem_idx   = idx_w'(r_cnt * array_dim + c_cnt);
    assign elem       = shadow[elem_idx];
    // Computed wide so base + offset never overflows before the final truncation.
    assign addr_wide  = wide_w'(base) + wide_w'(c_cnt) * wide_w'(rows_eff) + wide_w'(r_cnt);
    assign state_dbg  = state;

`ifdef OUTPUT_DRAIN_RELU_EN
    assign elem_out = elem[data_size-1] ? '0 : elem;
`else
    assign elem_out = elem;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = (rows_clamp == '0 || cols_clamp == '0) ? FINISH : WRITE;
            WRITE:   if (last_elem) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            base     <= '0;
            rows_eff <= '0;
            cols_eff <= '0;
            r_cnt    <= '0;
            c_cnt    <= '0;
            for (int i = 0; i < n_elems; i++) shadow[i] <= '0;
        end else if (!enable) begin
            ram_we <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < n_elems; i++)
                            shadow[i] <= result_in[i*data_size +: data_size];
                        base <= initial_address;
                        busy <= 1'b1;
                        done <= 1'b0;
                    end
                end
                LOAD: begin
                    rows_eff <= rows_clamp;
                    cols_eff <= cols_clamp;
                    r_cnt    <= '0;
                    c_cnt    <= '0;
                end
                WRITE: begin
                    ram_we   <= 1'b1;
                    ram_addr <= addr_wide[addr_width-1:0];
                    ram_din  <= elem_out;
                    if (row_wrap) begin
                        r_cnt <= '0;
                        c_cnt <= c_cnt + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_output_drain_control.sv
// Randomized bench for output_drain_control: a list-based model predicts every RAM write,
// its cycle of first write and the completion cycle.
module tb_output_drain_control;
    localparam int DS = 16;
    localparam int AS = 9;
    localparam int DW = 16;
    localparam int AW = 14;
    localparam int NE = AS * AS;
    localparam int W  = AW + DS;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b1;
    logic              start = 1'b0;
    logic [AW-1:0]     initial_address = '0;
    logic [DW-1:0]     out_rows = '0;
    logic [DW-1:0]     number_filters = '0;
    logic [DS*NE-1:0]  result_in = '0;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DS-1:0]     ram_din;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;

    logic [W-1:0]      exp_q[$];
    logic [DS-1:0]     tile [NE];
    int                n_cmp = 0;
    int                n_bad = 0;

    output_drain_control #(
        .data_size(DS), .array_size(AS), .dim_data_size(DW), .addr_width(AW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .initial_address(initial_address), .out_rows(out_rows),
        .number_filters(number_filters), .result_in(result_in),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // Clock and reset timing
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: every write the drain must produce, in order.
    task automatic build_model(input int base, input int rows, input int filters, output int n);
        int rows_e, cols_e, addr;
        logic [DS-1:0] d;
        rows_e = (rows > AS) ? AS : rows;
        cols_e = (filters > AS) ? AS : filters;
        exp_q.delete();
        for (int c = 0; c < cols_e; c++) begin
            for (int r = 0; r < rows_e; r++) begin
                addr = (base + c * rows_e + r) % (1 << AW);
                d = tile[r * AS + c];
`ifdef OUTPUT_DRAIN_RELU_EN
                if ($signed(d) < 0) d = '0;
`endif
                exp_q.push_back({addr[AW-1:0], d});
            end
        end
        n = rows_e * cols_e;
    endtask

    task automatic pack_tile();
        for (int i = 0; i < NE; i++) result_in[i*DS +: DS] = tile[i];
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < NE; i++) result_in[i*DS +: DS] = DS'($urandom);
        initial_address = AW'($urandom);
    endtask

    task automatic random_tile();
        for (int i = 0; i < NE; i++) tile[i] = DS'($urandom);
    endtask

    // Driver: one drain, optional 3-cycle enable stall after write number stall_after,
    // optional stray start pulse at edge pulse_at (edges counted from the start edge).
    task automatic run_drain(input int base, input int rows, input int filters,
                             input int stall_after, input int pulse_at);
        int n, writes, first_we, done_edge, stall_left, stalls;
        logic en_prev;
        logic [W-1:0] exp;
        build_model(base, rows, filters, n);
        initial_address = AW'(base);
        out_rows        = DW'(rows);
        number_filters  = DW'(filters);
        pack_tile();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_on_start", busy, 1);
        check_eq("done_clr_on_start", done, 0);
        scramble_inputs();
        writes = 0; first_we = -1; done_edge = -1; stall_left = 0; en_prev = 1'b1;
        stalls = (stall_after > 0 && stall_after <= n) ? 3 : 0;
        for (int k = 1; k <= 300 && done_edge < 0; k++) begin
            @(posedge clk); #1;
            if (!en_prev) begin
                check_eq("we_in_stall", ram_we, 0);
            end else if (ram_we) begin
                writes++;
                if (first_we < 0) first_we = k;
                if (exp_q.size() == 0) check_eq("extra_write", writes, n);
                else begin
                    exp = exp_q.pop_front();
                    check_eq("write_addr_data", {ram_addr, ram_din}, exp);
                end
            end
            if (done) done_edge = k;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) enable = 1'b1;
            end else if (en_prev && ram_we && writes == stall_after) begin
                enable = 1'b0;
                stall_left = 3;
            end
            start = (k == pulse_at);
            en_prev = enable;
        end
        start = 1'b0;
        enable = 1'b1;
        if (n > 0) check_eq("first_write_edge", first_we, 2);
        check_eq("write_count", writes, n);
        check_eq("done_edge", done_edge, 2 + n + stalls);
        check_eq("busy_at_done", busy, 0);
        check_eq("model_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        check_eq("quiet_after_done", ram_we, 0);
    endtask

    task automatic run_reset_mid();
        int n, writes;
        random_tile();
        build_model(40, 9, 9, n);
        initial_address = AW'(40);
        out_rows = DW'(9);
        number_filters = DW'(9);
        pack_tile();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        writes = 0;
        for (int k = 1; k <= 40 && writes < 10; k++) begin
            @(posedge clk); #1;
            if (ram_we) writes++;
        end
        check_eq("writes_before_reset", writes, 10);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_we", ram_we, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_done", done, 0);
        check_eq("rst_mid_addr", ram_addr, 0);
        reset = 1'b1;
        writes = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (ram_we) writes++;
        end
        check_eq("no_writes_after_reset", writes, 0);
        exp_q.delete();
    endtask

    initial begin
        int b, rr, ff, st;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_we", ram_we, 0);
        check_eq("reset_addr", ram_addr, 0);
        check_eq("reset_din", ram_din, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Full tile with (r,c) = r*16+c
        for (int r = 0; r < AS; r++)
            for (int c = 0; c < AS; c++) tile[r * AS + c] = DS'(r * 16 + c);
        run_drain(100, 9, 9, 0, 0);

        random_tile();
        run_drain(int'($urandom_range(0, 16383)), 4, 20, 0, 0);
        random_tile();
        run_drain(200, 9, 5, 5, 0);
        run_drain(50, 0, 7, 0, 0);
        random_tile();
        run_drain(300, 6, 6, 0, 5);
        run_reset_mid();
        random_tile();
        run_drain(16380, 9, 1, 0, 0);

        // Signed edge values in column 0
        random_tile();
        tile[0]      = 16'hFFFB;
        tile[AS]     = 16'h0000;
        tile[2 * AS] = 16'h0007;
        run_drain(10, 3, 1, 0, 0);

        for (int t = 0; t < 10; t++) begin
            random_tile();
            b  = int'($urandom_range(0, 16383));
            rr = int'($urandom_range(0, 12));
            ff = int'($urandom_range(0, 12));
            st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0;
            run_drain(b, rr, ff, st, int'($urandom_range(0, 8)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/output_drain_control.md
Name: output_drain_control

Overview:
- Write-side counterpart of the weight fill path: captures the systolic array's full result vector and serializes it, one element per cycle, into the output feature-map RAM.
- Elements are written filter-major from a base address.
- Sits between the array's result bus and the output RAM write port.
- Reports completion to the layer sequencer with `busy` and `done`.

Parameters:
- data_size, 16, width of one result element (two's complement)
- array_size, 9, systolic array dimension; result vector holds array_size*array_size elements
- dim_data_size, 16, width of dimension inputs
- addr_width, 14, output RAM address width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset
- enable  input  1  global advance; low freezes all state and forces ram_we=0 on the next edge
- start  input  1  request to capture result_in and begin draining; sampled only in IDLE with enable=1
- initial_address  input  addr_width  base write address
- out_rows  input  dim_data_size  valid rows (output pixels) per filter
- number_filters  input  dim_data_size  valid columns (filters)
- result_in  input  data_size*array_size*array_size  element (r,c) at bits [(r*array_size+c)*data_size +: data_size]
- ram_we  output  1  registered write strobe
- ram_addr  output  addr_width  registered write address
- ram_din  output  data_size  registered write data
- busy  output  1  high from start acceptance until FINISH completes
- done  output  1  level; set at end of drain, cleared when the next start is accepted

Behaviour:
- Reset (reset=0 at edge): state=IDLE; ram_we=0, ram_addr=0, ram_din=0, busy=0, done=0; counters and shadow register cleared. Reset wins over every other input, including mid-drain; no further writes are issued.
- States: IDLE, LOAD, WRITE, FINISH. All transitions require enable=1. With enable=0, state, counters and shadow hold, ram_we is driven 0, and ram_addr/ram_din hold.
- IDLE:
  - On start=1: latch result_in into the shadow register, latch initial_address, set busy=1 and done=0, go to LOAD.
  - start asserted outside IDLE is ignored.
- LOAD:
  - rows_eff = min(out_rows, array_size); cols_eff = min(number_filters, array_size).
  - If either is 0, go to FINISH with no writes. Otherwise clear c=0, r=0 and go to WRITE.
- WRITE, each enabled edge:
  - ram_we<=1.
  - ram_addr<=initial_address + c*rows_eff + r, truncated to addr_width (wraps modulo 2^addr_width).
  - ram_din<=shadow element (r,c).
  - Advance r. When r=rows_eff-1, set r=0 and c=c+1.
  - On the edge issuing (rows_eff-1, cols_eff-1), go to FINISH.
  - Total writes = rows_eff*cols_eff, on consecutive enabled cycles.
- FINISH: ram_we<=0, busy<=0, done<=1, state<=IDLE.
- Latency: with start accepted at edge T0, the first write is registered at edge T2. The last write is at T(1+N) for N elements. done=1 and busy=0 after edge T(2+N).
- The shadow register isolates the drain from result_in changes after capture.
- Address arithmetic uses at least addr_width+dim_data_size bits internally before truncation.

Optional Feature:
- Macro: OUTPUT_DRAIN_RELU_EN.
- When defined: ram_din is ReLU of the element; a negative signed value is written as 0, otherwise unchanged.
- When undefined: the element is written unmodified.
- Timing, addresses and write count are identical in both builds.

Test Plan:
1. Full tile:
   - Stimulus: array_size=9, out_rows=9, number_filters=9, initial_address=100, element (r,c)=r*16+c.
   - Required: 81 consecutive writes at addr 100..180; addr 100+c*9+r holds r*16+c; first ram_we at T2; done=1 at T83.
2. Partial tile with clamping:
   - Stimulus: out_rows=4, number_filters=20.
   - Required: cols clamp to 9; 36 writes; addr initial+c*4+r; done follows the last write by one cycle.
3. Enable stall:
   - Stimulus: drop enable for 3 cycles after the 5th write.
   - Required: ram_we=0 during the stall, no address skipped or duplicated, completion delayed by exactly 3 cycles.
4. Zero size and ignored start:
   - Stimulus: out_rows=0.
   - Required: no writes; done=1 two cycles after start.
   - Stimulus: start pulsed mid-drain.
   - Required: start ignored; write count unchanged.
5. Reset and wrap:
   - Stimulus: reset low during the 10th write.
   - Required: ram_we=0, busy=0, done=0 after the next edge.
   - Stimulus: initial_address=16380, 9 elements.
   - Required: addresses 16380..16383 then 0..4.
6. ReLU:
   - Stimulus: element values -5, 0, 7; build with OUTPUT_DRAIN_RELU_EN.
   - Required: ram_din 0, 0, 7.
   - Build without the macro. Required: ram_din 0xFFFB, 0, 7.
